// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, BOOT/RUN/HALT control and IF/ID register; ROM is read combinationally.
// One-cycle fetch latency; stall holds PC and IF/ID, any redirect overrides stall and inserts a bubble.
module fetch_stage #(
  parameter int          N          = 64,
  parameter logic [N-1:0] EXC_VECTOR = 'hD8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [N-1:0] branch_target,
  input  logic         eret,
  input  logic [N-1:0] elr,
  input  logic         exc,
  output logic [6:0]   imem_addr,
  input  logic [31:0]  imem_q,
  output logic [N-1:0] if_id_pc,
  output logic [31:0]  if_id_instr,
  output logic         if_id_valid,
  output logic         fetch_fault,
  output logic         halted
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [N-1:0] r_pc;
  logic [N-1:0] w_pc_nxt;
  logic [N-1:0] r_if_id_pc;
  logic [31:0]  r_if_id_instr;
  logic         r_if_id_valid;
  logic         r_fetch_fault;

  logic         w_ifid_ld;
  logic [N-1:0] w_ifid_pc_nxt;
  logic [31:0]  w_ifid_instr_nxt;
  logic         w_ifid_valid_nxt;
  logic         w_fault_set;
  logic         w_redirect;
  logic         w_bad_pc;

  assign w_redirect = exc | eret | branch_taken;
  assign w_bad_pc   = (r_pc[1:0] != 2'b00) | (|r_pc[N-1:9]);

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_ifid_ld        = 1'b0;
    w_ifid_pc_nxt    = '0;
    w_ifid_instr_nxt = '0;
    w_ifid_valid_nxt = 1'b0;
    w_fault_set      = 1'b0;
    case (r_state)
      S_BOOT: begin
        w_state_nxt = S_RUN;
        w_ifid_ld   = 1'b1;
      end
      S_RUN: begin
        w_fault_set = w_bad_pc;
        if (exc)               w_pc_nxt = EXC_VECTOR;
        else if (eret)         w_pc_nxt = elr;
        else if (branch_taken) w_pc_nxt = branch_target;
        else if (stall)        w_pc_nxt = r_pc;
        else if (!w_bad_pc && imem_q == 32'h0) begin
          // zero word is the halt marker: freeze on it
          w_pc_nxt    = r_pc;
          w_state_nxt = S_HALT;
        end else begin
          w_pc_nxt = r_pc + N'(4);
        end

        if (w_redirect) begin
          w_ifid_ld = 1'b1;
        end else if (!stall) begin
          w_ifid_ld = 1'b1;
          if (!w_bad_pc && imem_q != 32'h0) begin
            w_ifid_pc_nxt    = r_pc;
            w_ifid_instr_nxt = imem_q;
            w_ifid_valid_nxt = 1'b1;
          end
        end
      end
      S_HALT: begin
        w_ifid_ld = 1'b1;
        if (exc) begin
          w_pc_nxt    = EXC_VECTOR;
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_BOOT;
        w_ifid_ld   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_BOOT;
      r_pc          <= '0;
      r_if_id_pc    <= '0;
      r_if_id_instr <= '0;
      r_if_id_valid <= 1'b0;
      r_fetch_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_ifid_ld) begin
        r_if_id_pc    <= w_ifid_pc_nxt;
        r_if_id_instr <= w_ifid_instr_nxt;
        r_if_id_valid <= w_ifid_valid_nxt;
      end
      if (w_fault_set) r_fetch_fault <= 1'b1;
    end
  end

  assign imem_addr   = r_pc[8:2];
  assign if_id_pc    = r_if_id_pc;
  assign if_id_instr = r_if_id_instr;
  assign if_id_valid = r_if_id_valid;
  assign fetch_fault = r_fetch_fault;
  assign halted      = (r_state == S_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed vector table plus randomized run against a behavioural fetch model.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        eret;
  logic [63:0] elr;
  logic        exc;
  logic [6:0]  imem_addr;
  logic [31:0] imem_q;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        fetch_fault;
  logic        halted;

  logic [31:0] rom [128];
  assign imem_q = rom[imem_addr];

  fetch_stage #(.N(64), .EXC_VECTOR(64'hD8)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .eret(eret), .elr(elr), .exc(exc),
    .imem_addr(imem_addr), .imem_q(imem_q),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .fetch_fault(fetch_fault), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        s, b;
    logic [63:0] t;
    logic        e;
    logic [63:0] el;
    logic        x;
    logic [6:0]  addr;
    logic [63:0] ifpc;
    logic [31:0] instr;
    logic        valid, hlt, flt;
  } vec_t;

  function automatic vec_t v(input logic s, input logic b, input logic [63:0] t,
                             input logic e, input logic [63:0] el, input logic x,
                             input logic [6:0] a, input logic [63:0] p, input logic [31:0] i,
                             input logic vl, input logic h, input logic f);
    vec_t r;
    r.s = s; r.b = b; r.t = t; r.e = e; r.el = el; r.x = x;
    r.addr = a; r.ifpc = p; r.instr = i; r.valid = vl; r.hlt = h; r.flt = f;
    return r;
  endfunction

  task automatic set_in(input logic s, input logic b, input logic [63:0] t,
                        input logic e, input logic [63:0] el, input logic x);
    stall = s; branch_taken = b; branch_target = t; eret = e; elr = el; exc = x;
  endtask

  task automatic chk_all(input string tag, input logic [6:0] a, input logic [63:0] p,
                         input logic [31:0] i, input logic vl, input logic h, input logic f);
    chk({tag, ".imem_addr"}, 64'(imem_addr), 64'(a));
    chk({tag, ".if_id_pc"}, if_id_pc, p);
    chk({tag, ".if_id_instr"}, 64'(if_id_instr), 64'(i));
    chk({tag, ".if_id_valid"}, 64'(if_id_valid), 64'(vl));
    chk({tag, ".halted"}, 64'(halted), 64'(h));
    chk({tag, ".fetch_fault"}, 64'(fetch_fault), 64'(f));
  endtask

  // behavioural reference model
  localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2;
  int          m_mode;
  logic [63:0] m_pc, m_ifpc;
  logic [31:0] m_ifinstr;
  logic        m_ifvalid, m_fault;

  task automatic model_step();
    logic [31:0] word;
    logic        bad, redir;
    if (reset) begin
      m_mode = M_BOOT; m_pc = 0; m_ifpc = 0; m_ifinstr = 0; m_ifvalid = 0; m_fault = 0;
      return;
    end
    if (m_mode == M_BOOT) begin
      m_mode = M_RUN; m_ifpc = 0; m_ifinstr = 0; m_ifvalid = 0;
      return;
    end
    if (m_mode == M_HALT) begin
      if (exc) begin m_mode = M_RUN; m_pc = 64'hD8; end
      return;
    end
    word  = rom[m_pc[8:2]];
    bad   = (m_pc % 4 != 0) || (m_pc >= 64'd512);
    redir = exc || eret || branch_taken;
    if (bad) m_fault = 1;
    if (redir) begin
      m_ifpc = 0; m_ifinstr = 0; m_ifvalid = 0;
      m_pc = exc ? 64'hD8 : (eret ? elr : branch_target);
    end else if (!stall) begin
      if (bad) begin
        m_ifpc = 0; m_ifinstr = 0; m_ifvalid = 0;
        m_pc = m_pc + 4;
      end else if (word == 0) begin
        m_ifpc = 0; m_ifinstr = 0; m_ifvalid = 0;
        m_mode = M_HALT;
      end else begin
        m_ifpc = m_pc; m_ifinstr = word; m_ifvalid = 1;
        m_pc = m_pc + 4;
      end
    end
  endtask

  function automatic logic [63:0] rnd_target();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return 64'($urandom_range(0, 511)) | 64'd1;
    if (k == 1) return 64'h200 + 64'({$urandom_range(0, 255), 2'b00});
    return 64'({$urandom_range(0, 127), 2'b00});
  endfunction

  vec_t vt[$];

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 32'h1000_0000 | 32'(i);
    rom[0]  = 32'h8b1e03c9;
    rom[29] = 32'h0;

    vt.push_back(v(0,0,64'h0,0,64'h0,0,  7'd0, 64'h0,  32'h0,        0,0,0));
    vt.push_back(v(0,0,64'h0,0,64'h0,0,  7'd1, 64'h0,  32'h8b1e03c9, 1,0,0));
    vt.push_back(v(0,0,64'h0,0,64'h0,0,  7'd2, 64'h4,  32'h10000001, 1,0,0));
    vt.push_back(v(0,0,64'h0,0,64'h0,0,  7'd3, 64'h8,  32'h10000002, 1,0,0));
    vt.push_back(v(0,0,64'h0,0,64'h0,0,  7'd4, 64'hC,  32'h10000003, 1,0,0));
    for (int i = 0; i < 3; i++)
      vt.push_back(v(1,0,64'h0,0,64'h0,0, 7'd4, 64'hC, 32'h10000003, 1,0,0));
    vt.push_back(v(0,0,64'h0,0,64'h0,0,  7'd5, 64'h10, 32'h10000004, 1,0,0));
    vt.push_back(v(0,0,64'h0,0,64'h0,0,  7'd6, 64'h14, 32'h10000005, 1,0,0));
    vt.push_back(v(0,0,64'h0,0,64'h0,0,  7'd7, 64'h18, 32'h10000006, 1,0,0));
    vt.push_back(v(0,0,64'h0,0,64'h0,0,  7'd8, 64'h1C, 32'h10000007, 1,0,0));
    vt.push_back(v(0,1,64'h0,0,64'h0,1,  7'd54,64'h0,  32'h0,        0,0,0));
    vt.push_back(v(0,0,64'h0,0,64'h0,0,  7'd55,64'hD8, 32'h10000036, 1,0,0));
    vt.push_back(v(1,1,64'h100,0,64'h0,0,7'd64,64'h0,  32'h0,        0,0,0));
    vt.push_back(v(0,0,64'h0,1,64'h24,0, 7'd9, 64'h0,  32'h0,        0,0,0));
    vt.push_back(v(0,0,64'h0,0,64'h0,0,  7'd10,64'h24, 32'h10000009, 1,0,0));
    vt.push_back(v(0,1,64'h70,0,64'h0,0, 7'd28,64'h0,  32'h0,        0,0,0));
    vt.push_back(v(0,0,64'h0,0,64'h0,0,  7'd29,64'h70, 32'h1000001C, 1,0,0));
    vt.push_back(v(0,0,64'h0,0,64'h0,0,  7'd29,64'h0,  32'h0,        0,1,0));
    vt.push_back(v(0,1,64'h0,1,64'h0,0,  7'd29,64'h0,  32'h0,        0,1,0));
    vt.push_back(v(0,0,64'h0,0,64'h0,1,  7'd54,64'h0,  32'h0,        0,0,0));
    vt.push_back(v(0,0,64'h0,0,64'h0,0,  7'd55,64'hD8, 32'h10000036, 1,0,0));
    vt.push_back(v(0,1,64'h6,0,64'h0,0,  7'd1, 64'h0,  32'h0,        0,0,0));
    vt.push_back(v(0,0,64'h0,0,64'h0,0,  7'd2, 64'h0,  32'h0,        0,0,1));
    vt.push_back(v(0,1,64'h40,0,64'h0,0, 7'd16,64'h0,  32'h0,        0,0,1));
    vt.push_back(v(0,0,64'h0,0,64'h0,0,  7'd17,64'h40, 32'h10000010, 1,0,1));

    reset = 1'b1;
    set_in(0,0,64'h0,0,64'h0,0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 7'd0, 64'h0, 32'h0, 0, 0, 0);
    reset = 1'b0;

    for (int r = 0; r < vt.size(); r++) begin
      set_in(vt[r].s, vt[r].b, vt[r].t, vt[r].e, vt[r].el, vt[r].x);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", r), vt[r].addr, vt[r].ifpc, vt[r].instr,
              vt[r].valid, vt[r].hlt, vt[r].flt);
    end

    // asynchronous reset between edges must clear state at once
    set_in(0,0,64'h0,0,64'h0,0);
    #2;
    reset = 1'b1;
    #1;
    chk_all("async_rst", 7'd0, 64'h0, 32'h0, 0, 0, 0);

    // reset while halted, with redirects pending
    @(posedge clk); #1;
    reset = 1'b0;
    set_in(0,1,64'h70,0,64'h0,0);
    repeat (2) @(posedge clk);
    #1;
    set_in(0,0,64'h0,0,64'h0,0);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_halted", 64'(halted), 64'd1);
    set_in(1,1,64'h8,1,64'h8,1);
    reset = 1'b1;
    #1;
    chk_all("halt_rst", 7'd0, 64'h0, 32'h0, 0, 0, 0);
    @(posedge clk); #1;
    chk_all("halt_rst_hold", 7'd0, 64'h0, 32'h0, 0, 0, 0);

    // randomized run against the model
    for (int i = 0; i < 128; i++)
      rom[i] = ($urandom_range(0, 11) == 0) ? 32'h0 : ($urandom | 32'h1);
    model_step();
    for (int c = 0; c < 3000; c++) begin
      reset         = ($urandom_range(0, 39) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      branch_taken  = ($urandom_range(0, 7) == 0);
      branch_target = rnd_target();
      eret          = ($urandom_range(0, 11) == 0);
      elr           = rnd_target();
      exc           = ($urandom_range(0, 15) == 0);
      model_step();
      @(posedge clk);
      #1;
      chk_all($sformatf("rnd%0d", c), m_pc[8:2], m_ifpc, m_ifinstr, m_ifvalid,
              (m_mode == M_HALT), m_fault);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
